// File: rtl/time_counter_pkg.sv
// Shared types and defaults for the cascaded modulo time counter.
// Default chain is SS:MM style: units mod 10, tens mod 6 (digit 0 in the low bits).
package time_counter_pkg;

    localparam int DEF_DIGIT_W    = 4;
    localparam int DEF_NUM_DIGITS = 4;

    localparam logic [DEF_NUM_DIGITS*DEF_DIGIT_W-1:0] DEF_MODULI = {4'd6, 4'd10, 4'd6, 4'd10};

    typedef logic [DEF_DIGIT_W-1:0] digit_t;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_e;

endpackage

// File: rtl/mod_digit.sv
// Single modulo-N digit: clear > load > step, wraps at its modulus in either direction.
// terminal flags the carry/borrow condition for the next digit up the chain.
module mod_digit
    import time_counter_pkg::*;
#(
    parameter int DIGIT_W = DEF_DIGIT_W,
    parameter int MODULUS = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               step_in,
    input  count_dir_e         dir,
    input  logic               clear,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    output logic [DIGIT_W-1:0] value,
    output logic               terminal
);

    if (MODULUS < 2 || MODULUS > (2**DIGIT_W) - 1) begin : g_bad_modulus
        $error("mod_digit: MODULUS %0d out of range for DIGIT_W %0d", MODULUS, DIGIT_W);
    end

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);

    logic [DIGIT_W-1:0] value_next;

    always_comb begin
        terminal = (dir == DIR_UP) ? (value == MAX_V) : (value == '0);
    end

    always_comb begin
        value_next = value;
        if (clear) begin
            value_next = '0;
        end else if (load) begin
            value_next = load_digit;
        end else if (step_in) begin
            if (dir == DIR_UP) begin
                value_next = terminal ? '0 : value + 1'b1;
            end else begin
                value_next = terminal ? MAX_V : value - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else begin
            value <= value_next;
        end
    end

endmodule

// File: rtl/cascade_time_counter.sv
// Cascaded modulo digit counter with ripple carry/borrow, validated load and wrap pulse.
// Optional macro COUNTDOWN_HALT_EN: down-count stops (halts) at zero instead of wrapping.
module cascade_time_counter
    import time_counter_pkg::*;
#(
    parameter int                                NUM_DIGITS = DEF_NUM_DIGITS,
    parameter int                                DIGIT_W    = DEF_DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]     MODULI     = DEF_MODULI
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick_en,
    input  logic                          run,
    input  logic                          dir,
    input  logic                          clear,
    input  logic                          load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] digits,
    output logic                          wrap,
    output logic                          all_zero,
    output logic                          load_err
);

    count_dir_e              dir_e;
    logic [NUM_DIGITS-1:0]   terminal;
    logic [NUM_DIGITS-1:0]   step;
    logic [NUM_DIGITS-1:0]   digit_ok;
    logic                    load_legal;
    logic                    load_apply;
    logic                    count_en;
    logic                    halt_block;
    logic                    down_wrap;
    logic                    wrap_next;

    assign dir_e = count_dir_e'(dir);

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        assign digit_ok[i] = load_val[i*DIGIT_W +: DIGIT_W] < MODULI[i*DIGIT_W +: DIGIT_W];

        if (i == 0) begin : g_lsd
            assign step[i] = count_en;
        end else begin : g_upper
            assign step[i] = step[i-1] & terminal[i-1];
        end

        mod_digit #(
            .DIGIT_W (DIGIT_W),
            .MODULUS (int'(MODULI[i*DIGIT_W +: DIGIT_W]))
        ) u_digit (
            .clk        (clk),
            .reset      (reset),
            .step_in    (step[i]),
            .dir        (dir_e),
            .clear      (clear),
            .load       (load_apply),
            .load_digit (load_val[i*DIGIT_W +: DIGIT_W]),
            .value      (digits[i*DIGIT_W +: DIGIT_W]),
            .terminal   (terminal[i])
        );
    end

    assign load_legal = &digit_ok;
    assign load_apply = load & load_legal;
    assign all_zero   = (digits == '0);

`ifdef COUNTDOWN_HALT_EN
    logic halt;
    logic land_zero;

    // A down step lands on zero exactly when the current count is 1 (digit 0 is 1, the rest 0).
    always_comb begin
        land_zero = (digits[DIGIT_W-1:0] == DIGIT_W'(1));
        for (int unsigned i = 1; i < NUM_DIGITS; i++) begin
            land_zero = land_zero & (digits[i*DIGIT_W +: DIGIT_W] == '0);
        end
    end

    assign halt_block = halt & (dir_e == DIR_DOWN);
    assign down_wrap  = land_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt <= 1'b0;
        end else if (clear) begin
            halt <= 1'b0;
        end else if (load) begin
            if (load_legal) begin
                halt <= 1'b0;
            end
        end else if (count_en) begin
            halt <= (dir_e == DIR_DOWN) ? land_zero : 1'b0;
        end
    end
`else
    assign halt_block = 1'b0;
    assign down_wrap  = &terminal;
`endif

    assign count_en  = tick_en & run & ~clear & ~load & ~halt_block;
    assign wrap_next = count_en & ((dir_e == DIR_UP) ? (&terminal) : down_wrap);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= wrap_next;
            load_err <= ~clear & load & ~load_legal;
        end
    end

endmodule

// File: tb/tb_cascade_time_counter.sv
// Self-checking bench: directed vector table, async-reset sequence and randomized
// stimulus checked against a mixed-radix arithmetic model of the count.
module tb_cascade_time_counter;

    logic        clk;
    logic        reset;
    logic        tick_en;
    logic        run;
    logic        dir;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] digits;
    logic        wrap;
    logic        all_zero;
    logic        load_err;

    int passed = 0;
    int total  = 0;

    int mods[4] = '{10, 6, 10, 6};
    localparam int TOTAL = 3600;

    int mv;
    bit mw, me, mh;

    cascade_time_counter dut (
        .clk      (clk),
        .reset    (reset),
        .tick_en  (tick_en),
        .run      (run),
        .dir      (dir),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .digits   (digits),
        .wrap     (wrap),
        .all_zero (all_zero),
        .load_err (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr, ld, rn, dr, tk;
        logic [15:0] lv;
        logic [15:0] ed;
        logic        ew, ee;
    } vec_t;

    function automatic int to_val(input logic [15:0] d);
        int v = 0;
        int w = 1;
        for (int i = 0; i < 4; i++) begin
            v += int'(d[i*4 +: 4]) * w;
            w *= mods[i];
        end
        return v;
    endfunction

    function automatic logic [15:0] from_val(input int v);
        logic [15:0] d = '0;
        int r = v;
        for (int i = 0; i < 4; i++) begin
            d[i*4 +: 4] = 4'(r % mods[i]);
            r = r / mods[i];
        end
        return d;
    endfunction

    function automatic bit legal(input logic [15:0] d);
        for (int i = 0; i < 4; i++) begin
            if (int'(d[i*4 +: 4]) >= mods[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        mv = 0; mw = 0; me = 0; mh = 0;
    endtask

    task automatic model_step(input logic c, l, r, d, t, input logic [15:0] lv);
        mw = 0;
        me = 0;
        if (c) begin
            mv = 0; mh = 0;
        end else if (l) begin
            if (legal(lv)) begin
                mv = to_val(lv); mh = 0;
            end else begin
                me = 1;
            end
        end else if (t && r) begin
            if (d) begin
                mv = (mv + 1) % TOTAL;
                mw = (mv == 0);
                mh = 0;
            end else begin
`ifdef COUNTDOWN_HALT_EN
                if (!mh) begin
                    mv = (mv + TOTAL - 1) % TOTAL;
                    mw = (mv == 0);
                    mh = (mv == 0);
                end
`else
                mw = (mv == 0);
                mv = (mv + TOTAL - 1) % TOTAL;
`endif
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic cycle(input logic c, l, r, d, t, input logic [15:0] lv);
        clear = c; load = l; run = r; dir = d; tick_en = t; load_val = lv;
        @(posedge clk);
        model_step(c, l, r, d, t, lv);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".digits"},   digits,           from_val(mv));
        check({tag, ".wrap"},     16'(wrap),        16'(mw));
        check({tag, ".load_err"}, 16'(load_err),    16'(me));
        check({tag, ".all_zero"}, 16'(all_zero),    16'(mv == 0));
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0, 1, 1, 1, 0, 16'h5959, 16'h5959, 0, 0};
        tbl[1]  = '{0, 0, 1, 1, 1, 16'h0000, 16'h0000, 1, 0};
        tbl[2]  = '{0, 0, 1, 1, 0, 16'h0000, 16'h0000, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 0, 16'h1000, 16'h1000, 0, 0};
        tbl[4]  = '{0, 0, 1, 0, 1, 16'h0000, 16'h0959, 0, 0};
        tbl[5]  = '{0, 1, 1, 0, 1, 16'h6000, 16'h0959, 0, 1};
        tbl[6]  = '{0, 0, 1, 0, 0, 16'h0000, 16'h0959, 0, 0};
        tbl[7]  = '{0, 1, 1, 0, 1, 16'h0001, 16'h0001, 0, 0};
`ifdef COUNTDOWN_HALT_EN
        tbl[8]  = '{0, 0, 1, 0, 1, 16'h0000, 16'h0000, 1, 0};
        tbl[9]  = '{0, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0};
`else
        tbl[8]  = '{0, 0, 1, 0, 1, 16'h0000, 16'h0000, 0, 0};
        tbl[9]  = '{0, 0, 1, 0, 1, 16'h0000, 16'h5959, 1, 0};
`endif
        tbl[10] = '{1, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0};
        tbl[11] = '{0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0};
        tbl[12] = '{0, 1, 0, 1, 0, 16'h0009, 16'h0009, 0, 0};
        tbl[13] = '{0, 0, 1, 1, 1, 16'h0000, 16'h0010, 0, 0};
        tbl[14] = '{1, 1, 1, 1, 1, 16'h5959, 16'h0000, 0, 0};
        tbl[15] = '{0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0};

        reset = 1'b1; tick_en = 0; run = 0; dir = 1; clear = 0; load = 0; load_val = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset.digits",   digits,         16'h0000);
        check("reset.wrap",     16'(wrap),      16'h0);
        check("reset.load_err", 16'(load_err),  16'h0);
        check("reset.all_zero", 16'(all_zero),  16'h1);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1, 1, 1, '0);
            check("up10.wrap", 16'(wrap), 16'h0);
        end
        check("up10.digits", digits, 16'h0010);

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].clr, tbl[i].ld, tbl[i].rn, tbl[i].dr, tbl[i].tk, tbl[i].lv);
            check($sformatf("vec%0d.digits", i),   digits,        tbl[i].ed);
            check($sformatf("vec%0d.wrap", i),     16'(wrap),     16'(tbl[i].ew));
            check($sformatf("vec%0d.load_err", i), 16'(load_err), 16'(tbl[i].ee));
        end

        // Asynchronous reset between edges while counting.
        cycle(0, 1, 1, 1, 0, 16'h5958);
        cycle(0, 0, 1, 1, 1, '0);
        cycle(0, 0, 1, 1, 1, '0);
        check("pre_areset.digits", digits, 16'h0000);
        check("pre_areset.wrap",   16'(wrap), 16'h1);
        #2;
        reset = 1'b1;
        #1;
        check("areset.digits", digits,    16'h0000);
        check("areset.wrap",   16'(wrap), 16'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        for (int n = 0; n < 3000; n++) begin
            logic        c, l, r, t;
            logic [15:0] lv;
            if ($urandom_range(15) == 0) dir = ~dir;
            c = ($urandom_range(29) == 0);
            l = ($urandom_range(11) == 0);
            r = ($urandom_range(7) != 0);
            t = ($urandom_range(1) == 1);
            case ($urandom_range(5))
                0: lv = 16'h5959;
                1: lv = 16'h0001;
                2: lv = 16'h0000;
                3: lv = 16'($urandom);
                default: lv = from_val(int'($urandom_range(TOTAL - 1)));
            endcase
            cycle(c, l, r, dir, t, lv);
            check_model("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cascade_time_counter.md
Name: cascade_time_counter

Overview:
- Parametrised chain of modulo digit counters, e.g. SS:MM mod 10/6/10/6, for the stopwatch/watch datapath.
- Counts up or down on a single-cycle tick enable, with ripple carry/borrow between digits.
- Supports a validated parallel load and a synchronous clear.
- Fully synchronous to clk with no derived clocks; the chain-wrap indication is a one-cycle pulse.

Parameters:
- NUM_DIGITS, 4, number of cascaded digits; digit 0 is least significant.
- DIGIT_W, 4, bits per digit.
- MODULI, {4'd6,4'd10,4'd6,4'd10}, packed NUM_DIGITS*DIGIT_W modulus list; digit i occupies bits [i*DIGIT_W +: DIGIT_W]. Each modulus must be in 2..2^DIGIT_W-1; an elaboration-time check rejects any other value.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high.
- tick_en, input, 1, one-cycle count strobe (e.g. 1 Hz or 100 Hz enable).
- run, input, 1, counting permitted; tick_en is ignored while run=0.
- dir, input, 1, 1 = up, 0 = down.
- clear, input, 1, synchronous clear of all digits to 0.
- load, input, 1, synchronous parallel-load request.
- load_val, input, NUM_DIGITS*DIGIT_W, load value, packed the same way as MODULI.
- digits, output, NUM_DIGITS*DIGIT_W, current count.
- wrap, output, 1, one-cycle pulse when the whole chain rolls over.
- all_zero, output, 1, combinational; all digits are 0.
- load_err, output, 1, one-cycle pulse when a load is rejected.

Behaviour:
- Reset (asynchronous, active-high, clock clk): digits=0, wrap=0, load_err=0, halt flag=0. Reset value is independent of dir.
- Priority each cycle: reset > clear > load > count.
- clear=1: digits←0 and wrap←0. Any tick or load in the same cycle is dropped.
- load=1: the load is legal iff every digit of load_val is less than its modulus.
  - Legal: digits←load_val.
  - Illegal: digits unchanged and load_err pulses for 1 cycle.
  - Either way, a tick in the same cycle is dropped and wrap stays 0.
- Count step when tick_en & run & !clear & !load:
  - Up: digit i increments iff all lower digits equal MODULI[i]-1. A digit at MODULI[i]-1 that steps goes to 0.
  - Down: digit i decrements iff all lower digits equal 0. A digit at 0 that steps goes to MODULI[i]-1.
  - Digit 0 always steps.
- Carry and borrow are combinational across the chain; all digits update on the same edge. Latency is 1 cycle from tick to the updated digits.
- wrap is registered and asserted on the same edge as the rollover: up 'max → 0', down '0 → max'.
- A dir change takes effect on the next tick. No tick is lost or duplicated.
- run=0 freezes the count; load and clear still operate.
- Asynchronous reset asserted mid-count forces all outputs to reset values immediately.

Optional Feature:
- Macro: COUNTDOWN_HALT_EN.
- Defined:
  - A down-count step that makes all digits 0 sets an internal halt flag and pulses wrap once.
  - While halt=1, further down ticks are ignored and the count stays at 0.
  - Up ticks, clear, a legal load or reset release halt. Up ticks are counted in that same cycle.
- Undefined: no halt flag; down-count wraps from 0 to the maximum value per the normal rules.

Decomposition:
- Package time_counter_pkg:
  - DIGIT_W default.
  - Default MODULI constant.
  - typedef logic [DIGIT_W-1:0] digit_t.
  - enum count_dir_e {DIR_DOWN=0, DIR_UP=1}.
- Sub-module mod_digit, one instance per digit via generate:
  - Inputs: step_in, dir, clear, load, load_digit.
  - Outputs: value, terminal (combinational; at MODULI-1 when dir=up, at 0 when dir=down).
- The top level generates the carry chain, the load-legality AND-reduction, and the wrap/load_err/halt registers.

Test Plan:
- Reset, then run=1, dir=1, 10 ticks → digits={0,0,1,0}; wrap stays 0.
- Load 59:59, i.e. {5,9,5,9}, then 1 up tick → digits={0,0,0,0} and wrap=1 for exactly 1 cycle.
- Load 10:00, dir=0, 1 tick → digits={0,9,5,9} (09:59); wrap=0.
- Load {6,0,0,0}, where the tens modulus is 6 → load_err=1 for 1 cycle and digits unchanged. Load and tick in the same cycle → load wins; tick dropped.
- Down from {0,0,0,1}, 2 ticks:
  - Without COUNTDOWN_HALT_EN → 0 then {5,9,5,9}, wrap on the 2nd tick.
  - With COUNTDOWN_HALT_EN → 0 with wrap on the 1st tick, then stays 0.
- Assert reset asynchronously between edges mid-count → digits=0 immediately. run=0 with ticks → count frozen. clear and tick together → 0.
